// File: rtl/config_byte_streamer.sv
// config_byte_streamer: buffers one configuration command (target id, byte count and payload)
// and replays the payload on configId/configData as a contiguous burst, one byte per cycle.
// The burst is followed by a run of idle-ID cycles so that every receiver's byte counter
// restarts before the next burst.
//
// state | meaning
// IDLE  | waiting for a command; tracing follows trace_en
// LOAD  | collecting payload bytes into the buffer; bus stays idle
// SEND  | driving buffered bytes on the bus, one per cycle, no stalls
// GAP   | idle-ID cycles that reset the receivers' byte counters
module config_byte_streamer #(
  parameter int         MAX_BYTES  = 32,
  parameter logic [7:0] IDLE_ID    = 8'hFF,
  parameter int         GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trace_en,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_id,
  input  logic [7:0] cmd_len,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic [7:0] data_in,
  output logic       tracing,
  output logic [7:0] configId,
  output logic [7:0] configData,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CW = $clog2(MAX_BYTES + 1);
  localparam int AW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  // Length check is done on the full 8-bit command length, before truncation to CW bits.
  localparam logic [8:0]    MAX_LEN  = 9'(MAX_BYTES);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  state_t        state, state_nxt;
  logic [7:0]    buffer [0:MAX_BYTES-1];
  logic [7:0]    id_q;
  logic [CW-1:0] len_q;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;
  logic [GW-1:0] gap_cnt;

  logic cmd_fire, len_zero, len_bad, byte_fire, load_last, send_last, gap_last;

  // Handshakes, event flags and next-state selection.
  always_comb begin
    cmd_ready  = (state == IDLE);
    data_ready = (state == LOAD);
    cmd_fire   = cmd_valid && cmd_ready;
    len_zero   = (cmd_len == 8'd0);
    len_bad    = ({1'b0, cmd_len} > MAX_LEN);
    byte_fire  = data_valid && data_ready;
    load_last  = byte_fire && (wr_cnt == (len_q - CW'(1)));
    send_last  = (rd_cnt == len_q);
    gap_last   = (gap_cnt == '0);
    state_nxt  = state;
    case (state)
      IDLE:    if (cmd_fire && !len_zero && !len_bad) state_nxt = LOAD;
      LOAD:    if (load_last) state_nxt = SEND;
      SEND:    if (send_last) state_nxt = GAP;
      GAP:     if (gap_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Payload buffer; contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (byte_fire) buffer[wr_cnt[AW-1:0]] <= data_in;
  end

  // Registered bus outputs, status pulses and the load/send/gap counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tracing    <= 1'b0;
      configId   <= IDLE_ID;
      configData <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      id_q       <= 8'd0;
      len_q      <= '0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      gap_cnt    <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      busy <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          tracing  <= trace_en;
          configId <= IDLE_ID;
          if (cmd_fire) begin
            if (len_zero) done <= 1'b1;
            else if (len_bad) err <= 1'b1;
            else begin
              id_q    <= cmd_id;
              len_q   <= cmd_len[CW-1:0];
              wr_cnt  <= '0;
              tracing <= 1'b0;
            end
          end
        end
        LOAD: begin
          if (byte_fire) begin
            wr_cnt <= wr_cnt + CW'(1);
            if (load_last) begin
              // Byte 0 goes out the cycle after the last byte lands; for a one-byte
              // payload it is still on data_in rather than in the buffer.
              configId   <= id_q;
              configData <= (wr_cnt == '0) ? data_in : buffer[0];
              rd_cnt     <= CW'(1);
            end
          end
        end
        SEND: begin
          if (send_last) begin
            configId <= IDLE_ID;
            gap_cnt  <= GAP_LOAD;
          end else begin
            configData <= buffer[rd_cnt[AW-1:0]];
            rd_cnt     <= rd_cnt + CW'(1);
          end
        end
        GAP: begin
          if (gap_last) begin
            done    <= 1'b1;
            tracing <= trace_en;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
